// File: rtl/vga_timing_gen.sv
// Raster timing generator for the 800x600 @ 60 Hz path: pixel/line counters plus registered, aligned sync/blank/eof strobes.
// Define VGA_TIMING_CE_EN to add the `ce` pixel-advance enable port.
module vga_timing_gen #(
    parameter int H_ACTIVE = 800,
    parameter int H_FP     = 40,
    parameter int H_SYNC   = 128,
    parameter int H_BP     = 88,
    parameter int V_ACTIVE = 600,
    parameter int V_FP     = 1,
    parameter int V_SYNC   = 4,
    parameter int V_BP     = 23
) (
    input  logic        clk,
    input  logic        rst,
`ifdef VGA_TIMING_CE_EN
    input  logic        ce,
`endif
    output logic [10:0] hcount,
    output logic        hsync,
    output logic        hblnk,
    output logic [9:0]  vcount,
    output logic        vsync,
    output logic        vblnk,
    output logic        eof
);

    localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

    localparam logic [10:0] H_LAST     = 11'(H_TOTAL - 1);
    localparam logic [10:0] H_BLANK    = 11'(H_ACTIVE);
    localparam logic [10:0] H_SYNC_BEG = 11'(H_ACTIVE + H_FP);
    localparam logic [10:0] H_SYNC_END = 11'(H_ACTIVE + H_FP + H_SYNC - 1);
    localparam logic [9:0]  V_LAST     = 10'(V_TOTAL - 1);
    localparam logic [9:0]  V_BLANK    = 10'(V_ACTIVE);
    localparam logic [9:0]  V_SYNC_BEG = 10'(V_ACTIVE + V_FP);
    localparam logic [9:0]  V_SYNC_END = 10'(V_ACTIVE + V_FP + V_SYNC - 1);

    logic [10:0] hcount_q, hcount_d;
    logic [9:0]  vcount_q, vcount_d;
    logic        hsync_q, hsync_d;
    logic        hblnk_q, hblnk_d;
    logic        vsync_q, vsync_d;
    logic        vblnk_q, vblnk_d;
    logic        eof_q, eof_d;
    logic        advance;

`ifdef VGA_TIMING_CE_EN
    assign advance = ce;
`else
    assign advance = 1'b1;
`endif

    always_comb begin
        // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
        hcount_d = hcount_q;
        vcount_d = vcount_q;
        if (advance) begin
            if (hcount_q == H_LAST) begin
                hcount_d = '0;
                vcount_d = (vcount_q == V_LAST) ? '0 : vcount_q + 10'd1;
            end else begin
                hcount_d = hcount_q + 11'd1;
            end
        end

        // Decoding the next-state counters lets the strobes land on the same edge as the counters they describe.
        hblnk_d = (hcount_d >= H_BLANK);
        hsync_d = (hcount_d >= H_SYNC_BEG) && (hcount_d <= H_SYNC_END);
        vblnk_d = (vcount_d >= V_BLANK);
        vsync_d = (vcount_d >= V_SYNC_BEG) && (vcount_d <= V_SYNC_END);
        eof_d   = (hcount_d == H_LAST) && (vcount_d == V_LAST);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            hcount_q <= '0;
            vcount_q <= '0;
            hsync_q  <= 1'b0;
            hblnk_q  <= 1'b0;
            vsync_q  <= 1'b0;
            vblnk_q  <= 1'b0;
            eof_q    <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments so all state updates see the pre-edge values.
            hcount_q <= hcount_d;
            vcount_q <= vcount_d;
            hsync_q  <= hsync_d;
            hblnk_q  <= hblnk_d;
            vsync_q  <= vsync_d;
            vblnk_q  <= vblnk_d;
            eof_q    <= eof_d;
        end
    end

    assign hcount = hcount_q;
    assign vcount = vcount_q;
    assign hsync  = hsync_q;
    assign hblnk  = hblnk_q;
    assign vsync  = vsync_q;
    assign vblnk  = vblnk_q;
    assign eof    = eof_q;

endmodule

// File: tb/tb_vga_timing_gen.sv
// Directed bench for vga_timing_gen: a default-timing instance plus a reduced-timing instance for whole-frame behaviour.
module tb_vga_timing_gen;

    logic clk   = 1'b0;
    logic rst_d = 1'b0;
    logic rst_s = 1'b0;
`ifdef VGA_TIMING_CE_EN
    logic ce_d = 1'b1;
    logic ce_s = 1'b1;
`endif

    logic [10:0] d_hcount, s_hcount;
    logic [9:0]  d_vcount, s_vcount;
    logic        d_hsync, d_hblnk, d_vsync, d_vblnk, d_eof;
    logic        s_hsync, s_hblnk, s_vsync, s_vblnk, s_eof;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    vga_timing_gen dut (
        .clk    (clk),
        .rst    (rst_d),
`ifdef VGA_TIMING_CE_EN
        .ce     (ce_d),
`endif
        .hcount (d_hcount),
        .hsync  (d_hsync),
        .hblnk  (d_hblnk),
        .vcount (d_vcount),
        .vsync  (d_vsync),
        .vblnk  (d_vblnk),
        .eof    (d_eof)
    );

    // Small raster: 32 pixels x 17 lines, hblnk>=20, hsync 23..27, vblnk>=10, vsync 12..14.
    vga_timing_gen #(
        .H_ACTIVE(20), .H_FP(3), .H_SYNC(5), .H_BP(4),
        .V_ACTIVE(10), .V_FP(2), .V_SYNC(3), .V_BP(2)
    ) dut_s (
        .clk    (clk),
        .rst    (rst_s),
`ifdef VGA_TIMING_CE_EN
        .ce     (ce_s),
`endif
        .hcount (s_hcount),
        .hsync  (s_hsync),
        .hblnk  (s_hblnk),
        .vcount (s_vcount),
        .vsync  (s_vsync),
        .vblnk  (s_vblnk),
        .eof    (s_eof)
    );

    // Expected {hsync, hblnk, vsync, vblnk} for the default raster.
    function automatic logic [3:0] d_strobes(input int h, input int v);
        return {(h >= 840 && h <= 967), (h >= 800), (v >= 601 && v <= 604), (v >= 600)};
    endfunction

    function automatic logic [3:0] s_strobes(input int h, input int v);
        return {(h >= 23 && h <= 27), (h >= 20), (v >= 12 && v <= 14), (v >= 10)};
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Called 1 time unit after an edge; the release lands well before the next edge.
    task automatic restart_d();
        rst_d = 1'b0;
        #2;
        rst_d = 1'b1;
    endtask

    task automatic restart_s();
        rst_s = 1'b0;
        #2;
        rst_s = 1'b1;
    endtask

    task automatic test_reset();
        rst_d = 1'b0;
        rst_s = 1'b0;
        repeat (5) @(posedge clk);
        #1;
        checks++;
        if ({d_hcount, d_vcount, d_hsync, d_hblnk, d_vsync, d_vblnk, d_eof} !== '0) begin
            failures++;
            $display("FAIL reset_hold_default: hcount=%0d vcount=%0d hs/hb/vs/vb/eof=%b%b%b%b%b, required all 0",
                     d_hcount, d_vcount, d_hsync, d_hblnk, d_vsync, d_vblnk, d_eof);
        end
        checks++;
        if ({s_hcount, s_vcount, s_hsync, s_hblnk, s_vsync, s_vblnk, s_eof} !== '0) begin
            failures++;
            $display("FAIL reset_hold_small: hcount=%0d vcount=%0d hs/hb/vs/vb/eof=%b%b%b%b%b, required all 0",
                     s_hcount, s_vcount, s_hsync, s_hblnk, s_vsync, s_vblnk, s_eof);
        end
        rst_d = 1'b1;
        rst_s = 1'b1;
        step();
        checks++;
        if (d_hcount !== 11'd1 || d_vcount !== 10'd0 || {d_hsync, d_hblnk, d_vsync, d_vblnk, d_eof} !== 5'b0) begin
            failures++;
            $display("FAIL first_edge_default: hcount=%0d vcount=%0d strobes=%b%b%b%b%b, required hcount=1 vcount=0 strobes=00000",
                     d_hcount, d_vcount, d_hsync, d_hblnk, d_vsync, d_vblnk, d_eof);
        end
        checks++;
        if (s_hcount !== 11'd1 || s_vcount !== 10'd0 || {s_hsync, s_hblnk, s_vsync, s_vblnk, s_eof} !== 5'b0) begin
            failures++;
            $display("FAIL first_edge_small: hcount=%0d vcount=%0d strobes=%b%b%b%b%b, required hcount=1 vcount=0 strobes=00000",
                     s_hcount, s_vcount, s_hsync, s_hblnk, s_vsync, s_vblnk, s_eof);
        end
    endtask

    task automatic test_horizontal();
        int   hb_rise = -1, hs_rise = -1, hs_fall = -1;
        int   hb_cnt = 0, hs_cnt = 0, bad = 0, bad_cyc = -1;
        int   pre_h = -1, pre_v = -1, post_h = -1, post_v = -1;
        int   eh, ev;
        logic prev_hb = 1'b0, prev_hs = 1'b0;
        restart_d();
        for (int cyc = 1; cyc <= 1100; cyc++) begin
            step();
            eh = cyc % 1056;
            ev = cyc / 1056;
            if (d_hcount !== 11'(eh) || d_vcount !== 10'(ev) || d_eof !== 1'b0 ||
                {d_hsync, d_hblnk, d_vsync, d_vblnk} !== d_strobes(eh, ev)) begin
                if (bad == 0) bad_cyc = cyc;
                bad++;
            end
            if (d_hblnk === 1'b1 && prev_hb === 1'b0 && hb_rise < 0) hb_rise = int'(d_hcount);
            if (d_hsync === 1'b1 && prev_hs === 1'b0 && hs_rise < 0) hs_rise = int'(d_hcount);
            if (d_hsync === 1'b0 && prev_hs === 1'b1 && hs_fall < 0) hs_fall = int'(d_hcount);
            if (cyc <= 1056 && d_hblnk === 1'b1) hb_cnt++;
            if (cyc <= 1056 && d_hsync === 1'b1) hs_cnt++;
            if (cyc == 1055) begin pre_h = int'(d_hcount); pre_v = int'(d_vcount); end
            if (cyc == 1056) begin post_h = int'(d_hcount); post_v = int'(d_vcount); end
            prev_hb = d_hblnk;
            prev_hs = d_hsync;
        end
        checks++;
        if (hb_rise != 800) begin
            failures++;
            $display("FAIL hblnk_rise: hcount=%0d, required 800", hb_rise);
        end
        checks++;
        if (hs_rise != 840) begin
            failures++;
            $display("FAIL hsync_rise: hcount=%0d, required 840", hs_rise);
        end
        checks++;
        if (hs_fall != 968) begin
            failures++;
            $display("FAIL hsync_fall: hcount=%0d, required 968", hs_fall);
        end
        checks++;
        if (hb_cnt != 256 || hs_cnt != 128) begin
            failures++;
            $display("FAIL line_widths: hblnk=%0d hsync=%0d cycles, required 256 and 128", hb_cnt, hs_cnt);
        end
        checks++;
        if (pre_h != 1055 || pre_v != 0 || post_h != 0 || post_v != 1) begin
            failures++;
            $display("FAIL line_wrap: (%0d,%0d)->(%0d,%0d), required (1055,0)->(0,1)", pre_h, pre_v, post_h, post_v);
        end
        checks++;
        if (bad != 0) begin
            failures++;
            $display("FAIL line_scan: %0d bad cycles, first at cycle %0d, required 0", bad, bad_cyc);
        end
    endtask

    task automatic test_vertical();
        int   vb_rise_h = -1, vb_rise_v = -1, vs_rise_h = -1, vs_rise_v = -1, vs_fall_h = -1, vs_fall_v = -1;
        int   vs_cnt = 0, vb_cnt = 0, bad = 0, bad_cyc = -1;
        int   eh, ev;
        logic prev_vb = 1'b0, prev_vs = 1'b0;
        restart_s();
        for (int cyc = 1; cyc <= 584; cyc++) begin
            step();
            eh = cyc % 32;
            ev = (cyc / 32) % 17;
            if (s_hcount !== 11'(eh) || s_vcount !== 10'(ev) || s_eof !== (eh == 31 && ev == 16) ||
                {s_hsync, s_hblnk, s_vsync, s_vblnk} !== s_strobes(eh, ev)) begin
                if (bad == 0) bad_cyc = cyc;
                bad++;
            end
            if (s_vblnk === 1'b1 && prev_vb === 1'b0 && vb_rise_v < 0) begin
                vb_rise_h = int'(s_hcount); vb_rise_v = int'(s_vcount);
            end
            if (s_vsync === 1'b1 && prev_vs === 1'b0 && vs_rise_v < 0) begin
                vs_rise_h = int'(s_hcount); vs_rise_v = int'(s_vcount);
            end
            if (s_vsync === 1'b0 && prev_vs === 1'b1 && vs_fall_v < 0) begin
                vs_fall_h = int'(s_hcount); vs_fall_v = int'(s_vcount);
            end
            if (cyc <= 544 && s_vsync === 1'b1) vs_cnt++;
            if (cyc <= 544 && s_vblnk === 1'b1) vb_cnt++;
            prev_vb = s_vblnk;
            prev_vs = s_vsync;
        end
        checks++;
        if (vb_rise_h != 0 || vb_rise_v != 10) begin
            failures++;
            $display("FAIL vblnk_rise: at (%0d,%0d), required (0,10)", vb_rise_h, vb_rise_v);
        end
        checks++;
        if (vs_rise_h != 0 || vs_rise_v != 12 || vs_fall_h != 0 || vs_fall_v != 15) begin
            failures++;
            $display("FAIL vsync_edges: rise (%0d,%0d) fall (%0d,%0d), required (0,12) and (0,15)",
                     vs_rise_h, vs_rise_v, vs_fall_h, vs_fall_v);
        end
        checks++;
        if (vs_cnt != 96 || vb_cnt != 224) begin
            failures++;
            $display("FAIL frame_widths: vsync=%0d vblnk=%0d cycles, required 96 and 224", vs_cnt, vb_cnt);
        end
        checks++;
        if (bad != 0) begin
            failures++;
            $display("FAIL frame_scan: %0d bad cycles, first at cycle %0d, required 0", bad, bad_cyc);
        end
    endtask

    task automatic test_frame_wrap();
        int   eof_cnt = 0, first_eof = -1, last_eof = -1, bad_pos = 0, bad_next = 0;
        logic prev_eof = 1'b0;
        restart_s();
        for (int cyc = 1; cyc <= 1640; cyc++) begin
            step();
            if (prev_eof === 1'b1 && (s_hcount !== 11'd0 || s_vcount !== 10'd0 || s_eof !== 1'b0)) bad_next++;
            if (s_eof === 1'b1) begin
                eof_cnt++;
                if (first_eof < 0) first_eof = cyc;
                last_eof = cyc;
                if (s_hcount !== 11'd31 || s_vcount !== 10'd16) bad_pos++;
            end
            prev_eof = s_eof;
        end
        checks++;
        if (eof_cnt != 3) begin
            failures++;
            $display("FAIL eof_count: %0d strobes in 3 frames, required 3", eof_cnt);
        end
        checks++;
        if (first_eof != 543 || last_eof - first_eof != 1088) begin
            failures++;
            $display("FAIL eof_period: first at %0d span %0d, required 543 and 1088", first_eof, last_eof - first_eof);
        end
        checks++;
        if (bad_pos != 0) begin
            failures++;
            $display("FAIL eof_position: %0d strobes away from (31,16), required 0", bad_pos);
        end
        checks++;
        if (bad_next != 0) begin
            failures++;
            $display("FAIL frame_wrap: %0d cycles after eof not (0,0) with eof=0, required 0", bad_next);
        end
    endtask

    task automatic test_async_reset();
        restart_d();
        repeat (1556) step();
        checks++;
        if (d_hcount !== 11'd500 || d_vcount !== 10'd1) begin
            failures++;
            $display("FAIL async_setup_default: (%0d,%0d), required (500,1)", d_hcount, d_vcount);
        end
        #3 rst_d = 1'b0;
        #1;
        checks++;
        if ({d_hcount, d_vcount, d_hsync, d_hblnk, d_vsync, d_vblnk, d_eof} !== '0) begin
            failures++;
            $display("FAIL async_clear_default: hcount=%0d vcount=%0d strobes=%b%b%b%b%b, required all 0",
                     d_hcount, d_vcount, d_hsync, d_hblnk, d_vsync, d_vblnk, d_eof);
        end
        step();
        checks++;
        if ({d_hcount, d_vcount, d_hsync, d_hblnk, d_vsync, d_vblnk, d_eof} !== '0) begin
            failures++;
            $display("FAIL async_hold_default: hcount=%0d vcount=%0d, required all 0 while held", d_hcount, d_vcount);
        end
        rst_d = 1'b1;
        step();
        checks++;
        if (d_hcount !== 11'd1 || d_vcount !== 10'd0) begin
            failures++;
            $display("FAIL async_restart_default: (%0d,%0d), required (1,0)", d_hcount, d_vcount);
        end

        restart_s();
        repeat (441) step();
        checks++;
        if (s_hcount !== 11'd25 || s_vcount !== 10'd13 || {s_hsync, s_hblnk, s_vsync, s_vblnk} !== 4'b1111) begin
            failures++;
            $display("FAIL async_setup_small: (%0d,%0d) strobes=%b%b%b%b, required (25,13) 1111",
                     s_hcount, s_vcount, s_hsync, s_hblnk, s_vsync, s_vblnk);
        end
        #3 rst_s = 1'b0;
        #1;
        checks++;
        if ({s_hcount, s_vcount, s_hsync, s_hblnk, s_vsync, s_vblnk, s_eof} !== '0) begin
            failures++;
            $display("FAIL async_clear_small: hcount=%0d vcount=%0d strobes=%b%b%b%b%b, required all 0",
                     s_hcount, s_vcount, s_hsync, s_hblnk, s_vsync, s_vblnk, s_eof);
        end
        rst_s = 1'b1;
        step();
        checks++;
        if (s_hcount !== 11'd1 || s_vcount !== 10'd0 || {s_hsync, s_hblnk, s_vsync, s_vblnk, s_eof} !== 5'b0) begin
            failures++;
            $display("FAIL async_restart_small: (%0d,%0d), required (1,0) with strobes 0", s_hcount, s_vcount);
        end
    endtask

`ifdef VGA_TIMING_CE_EN
    task automatic test_ce();
        int          bad_hold = 0, wrap1 = -1, wrap2 = -1, adv = 0;
        logic [10:0] pre_h;
        logic [9:0]  pre_v;
        logic [4:0]  pre_s;
        restart_d();
        for (int cyc = 1; cyc <= 4300; cyc++) begin
            ce_d  = (cyc % 2 == 1);
            pre_h = d_hcount;
            pre_v = d_vcount;
            pre_s = {d_hsync, d_hblnk, d_vsync, d_vblnk, d_eof};
            step();
            if (ce_d) adv++;
            if (!ce_d && (d_hcount !== pre_h || d_vcount !== pre_v ||
                          {d_hsync, d_hblnk, d_vsync, d_vblnk, d_eof} !== pre_s)) bad_hold++;
            if (d_hcount === 11'd0 && pre_h === 11'd1055) begin
                if (wrap1 < 0) wrap1 = cyc;
                else if (wrap2 < 0) wrap2 = cyc;
            end
        end
        ce_d = 1'b1;
        checks++;
        if (bad_hold != 0) begin
            failures++;
            $display("FAIL ce_hold: %0d ce=0 cycles changed outputs, required 0", bad_hold);
        end
        checks++;
        if (wrap2 - wrap1 != 2112) begin
            failures++;
            $display("FAIL ce_line_period: %0d cycles, required 2112", wrap2 - wrap1);
        end
        checks++;
        if (d_hcount !== 11'(adv % 1056) || d_vcount !== 10'(adv / 1056)) begin
            failures++;
            $display("FAIL ce_position: (%0d,%0d), required (%0d,%0d)", d_hcount, d_vcount, adv % 1056, adv / 1056);
        end
    endtask
`endif

    initial begin
        test_reset();
        test_horizontal();
        test_vertical();
        test_frame_wrap();
        test_async_reset();
`ifdef VGA_TIMING_CE_EN
        test_ce();
`endif
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/vga_timing_gen.md
# vga_timing_gen

Raster timing generator for the 800x600 @ 60 Hz display path. Produces pixel/line counters plus sync and blanking strobes, all registered and mutually aligned, and feeds them directly to the menu and game draw stages. Those stages then produce RGB and a delayed copy of the sync signals.

## Interface
- H_ACTIVE, 800, visible pixels per line
- H_FP, 40, horizontal front porch (pixels)
- H_SYNC, 128, horizontal sync width (pixels)
- H_BP, 88, horizontal back porch (pixels); H_TOTAL = sum = 1056, must be ≤ 2048
- V_ACTIVE, 600, visible lines per frame
- V_FP, 1, vertical front porch (lines)
- V_SYNC, 4, vertical sync width (lines)
- V_BP, 23, vertical back porch (lines); V_TOTAL = sum = 628, must be ≤ 1024
- clk  in  1  pixel clock, 40 MHz
- rst  in  1  asynchronous, active-low reset
- ce  in  1  pixel advance enable; present only with VGA_TIMING_CE_EN
- hcount  out  11  current pixel column, 0..H_TOTAL-1
- hsync  out  1  horizontal sync, active-high
- hblnk  out  1  horizontal blanking
- vcount  out  10  current line, 0..V_TOTAL-1
- vsync  out  1  vertical sync, active-high
- vblnk  out  1  vertical blanking
- eof  out  1  one-cycle end-of-frame strobe

## Operation
- Each advance: if hcount == H_TOTAL-1, hcount ← 0, else hcount + 1.
- vcount changes only on an hcount wrap: if vcount == V_TOTAL-1, vcount ← 0, else vcount + 1.
- Line and frame wrap are simultaneous at (H_TOTAL-1, V_TOTAL-1) → (0, 0).
- Decodes are functions of the counter values shown in the same cycle:
  - hblnk = hcount ≥ H_ACTIVE
  - hsync = H_ACTIVE+H_FP ≤ hcount ≤ H_ACTIVE+H_FP+H_SYNC-1, i.e. 840..967 at defaults
  - vblnk = vcount ≥ V_ACTIVE
  - vsync = V_ACTIVE+V_FP ≤ vcount ≤ V_ACTIVE+V_FP+V_SYNC-1, i.e. 601..604 at defaults
  - eof = (hcount == H_TOTAL-1) && (vcount == V_TOTAL-1)
- Implementation: every decode is registered and computed from the next-state counter values, with no combinational path from counter to output.
- All arithmetic is unsigned at counter width. Counters never exceed TOTAL-1.
- Reset (asserted, async): hcount=0, vcount=0, hsync=0, hblnk=0, vsync=0, vblnk=0, eof=0.
- After release, the first rising clk advances to hcount=1.
- Reset mid-frame: all outputs jump to reset values immediately, without waiting for a clock edge.

## Timing
- Zero relative skew: all seven outputs change on the same clk edge.
- Line period is H_TOTAL clk cycles. Frame period is H_TOTAL·V_TOTAL = 663 168 cycles at defaults.
- Per line: hsync high for H_SYNC cycles, hblnk high for H_TOTAL-H_ACTIVE = 256 cycles.
- Per frame: vsync high for V_SYNC·H_TOTAL cycles.
- vsync/vblnk edges coincide with hcount = 0.
- eof is high for exactly one cycle per frame, the cycle before (0,0).
- No handshake; the consumer samples outputs every cycle.

## Configuration
- VGA_TIMING_CE_EN defined: `ce` port exists.
  - Counters and all registered outputs hold while ce = 0.
  - eof, if high, stays high while ce = 0 and drops on the first advance.
  - Used to derive 800x600 timing from a 2× fast clock.
- Undefined: no `ce` port; counters advance on every clk.

## Test plan
- Reset: hold rst=0 for 5 clocks, then release.
  - During reset: all outputs 0.
  - First edge after release: hcount=1, vcount=0, all strobes 0.
- Horizontal decode across line 0:
  - hblnk rises at hcount=800.
  - hsync rises at 840 and falls at 968.
  - hcount wraps 1055→0 and vcount goes 0→1 on the same edge.
- Vertical decode across a frame:
  - vblnk rises at (0,600).
  - vsync is high only for vcount 601..604.
  - Measured vsync width = 4224 cycles.
- Frame wrap:
  - eof=1 only at (1055,627); the next edge gives (0,0) with eof=0.
  - Exactly one eof per 663 168 cycles over 3 frames.
- Async reset mid-frame:
  - Drive rst=0 between clock edges at (500,300); all outputs are 0 before the next edge.
  - After release, the counters restart from (0,0).
- With VGA_TIMING_CE_EN, drive ce alternating 1/0:
  - Counters advance every other clk.
  - Line period = 2112 clk cycles.
  - Outputs are stable during ce=0 cycles.
